// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan sequencer: state encoding,
// channel geometry and the enabled-channel search used to step sel.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } next_ch_t;

    function automatic next_ch_t lowest_set(input logic [NUM_CH-1:0] mask);
        next_ch_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = SEL_W'(i);
            end
        end
        return r;
    endfunction

    // Only channels strictly above cur qualify, so a scan never wraps around.
    function automatic next_ch_t next_enabled(input logic [NUM_CH-1:0] mask,
                                              input logic [SEL_W-1:0]  cur);
        logic [NUM_CH-1:0] above;
        for (int i = 0; i < NUM_CH; i++) begin
            above[i] = mask[i] && (i > int'(cur));
        end
        return lowest_set(above);
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 bit multiplexer scanned by mux_scan_ctrl.
module mux_4_1 (
    input  logic [3:0] d_in,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = d_in[sel];

endmodule

// File: rtl/mux_scan_settle_cnt.sv
// Loadable settle down-counter; zero marks the cycle on which mux_y is sampled.
module mux_scan_settle_cnt #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load wins over a decrement; the counter parks at zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(SETTLE_CYCLES);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a 4:1 bit mux, samples each after a settle
// time and hands the four captured bits out as one valid/ready snapshot.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_mask,
    output logic [1:0] sel,
    input  logic       mux_y,
    output logic       busy,
    output logic       snap_valid,
    input  logic       snap_ready,
    output logic [3:0] snap_data,
    output logic       start_drop
);

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] work_q, work_d;
    logic [NUM_CH-1:0] snap_data_q, snap_data_d;
    logic              snap_valid_q, snap_valid_d;
    logic              busy_q, busy_d;
    logic              start_drop_q, start_drop_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    next_ch_t          first_ch, next_ch;

    mux_scan_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        work_d       = work_q;
        snap_data_d  = snap_data_q;
        snap_valid_d = snap_valid_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        start_drop_d = start && (state_q != IDLE);
        first_ch     = lowest_set(ch_mask);
        next_ch      = next_enabled(mask_q, sel_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    work_d = '0;
                    // An empty mask still produces a (zero) snapshot.
                    if (!first_ch.found) begin
                        snap_data_d  = '0;
                        snap_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        sel_d    = first_ch.idx;
                        cnt_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    work_d[sel_q] = mux_y;
                    if (next_ch.found) begin
                        sel_d    = next_ch.idx;
                        cnt_load = 1'b1;
                    end else begin
                        snap_data_d  = work_d;
                        snap_valid_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (snap_ready) begin
                    snap_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            mask_q       <= '0;
            work_q       <= '0;
            snap_data_q  <= '0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            work_q       <= work_d;
            snap_data_q  <= snap_data_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
            start_drop_q <= start_drop_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;
    assign start_drop = start_drop_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: mux_scan_ctrl (settle 2 and settle 0 builds) driving
// mux_4_1, checked against a scan model of visit order, latency and data.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] ch_mask;
    logic       snap_ready;
    logic [3:0] mux_in;

    logic [1:0] sel2, sel0;
    logic       y2, y0;
    logic       busy2, busy0;
    logic       valid2, valid0;
    logic [3:0] data2, data0;
    logic       drop2, drop0;

    int checks   = 0;
    int failures = 0;
    bit use0     = 1'b0;
    int cur_s    = 2;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
        .sel(sel2), .mux_y(y2), .busy(busy2), .snap_valid(valid2),
        .snap_ready(snap_ready), .snap_data(data2), .start_drop(drop2)
    );
    mux_4_1 u_mux2 (.d_in(mux_in), .sel(sel2), .y(y2));

    mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
        .sel(sel0), .mux_y(y0), .busy(busy0), .snap_valid(valid0),
        .snap_ready(snap_ready), .snap_data(data0), .start_drop(drop0)
    );
    mux_4_1 u_mux0 (.d_in(mux_in), .sel(sel0), .y(y0));

    function automatic logic [1:0] o_sel();   return use0 ? sel0   : sel2;   endfunction
    function automatic logic       o_busy();  return use0 ? busy0  : busy2;  endfunction
    function automatic logic       o_valid(); return use0 ? valid0 : valid2; endfunction
    function automatic logic [3:0] o_data();  return use0 ? data0  : data2;  endfunction
    function automatic logic       o_drop();  return use0 ? drop0  : drop2;  endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] m,
                                 input logic [3:0] d, input logic rdy);
        start      = st;
        ch_mask    = m;
        mux_in     = d;
        snap_ready = rdy;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ":sel"},   32'(o_sel()),   32'd0);
        checkOutput({tag, ":busy"},  32'(o_busy()),  32'd0);
        checkOutput({tag, ":valid"}, 32'(o_valid()), 32'd0);
        checkOutput({tag, ":data"},  32'(o_data()),  32'd0);
        checkOutput({tag, ":drop"},  32'(o_drop()),  32'd0);
    endtask

    // One full scan: observe visit order, latency and snapshot, then hold
    // the snapshot for 'hold' cycles with ignored starts before accepting it.
    task automatic runScan(input logic [3:0] mask, input logic [3:0] din,
                           input int hold, input string tag);
        int         edges;
        int         runs_sel[$];
        int         runs_len[$];
        int         exp_sel[$];
        logic [1:0] sel_before;
        logic [3:0] exp_data;
        bit         seen;

        @(negedge clk);
        sel_before = o_sel();
        exp_data   = mask & din;
        for (int i = 0; i < 4; i++) if (mask[i]) exp_sel.push_back(i);
        applyStimulus(1'b1, mask, din, hold == 0);
        edges = 0;
        seen  = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start   = 1'b0;
            ch_mask = 4'($urandom);
            if (n == 0) checkOutput({tag, ":no_drop_on_accept"}, 32'(o_drop()), 32'd0);
            if (o_valid()) begin
                seen = 1'b1;
            end else if (runs_sel.size() > 0 && runs_sel[runs_sel.size()-1] == int'(o_sel())) begin
                runs_len[runs_len.size()-1]++;
            end else begin
                runs_sel.push_back(int'(o_sel()));
                runs_len.push_back(1);
            end
        end
        checkOutput({tag, ":valid_seen"}, 32'(seen), 32'd1);
        if (!seen) return;

        checkOutput({tag, ":latency"}, 32'(edges), 32'(exp_sel.size() * (cur_s + 1) + 1));
        checkOutput({tag, ":data"}, 32'(o_data()), 32'(exp_data));
        checkOutput({tag, ":busy"}, 32'(o_busy()), 32'd1);
        checkOutput({tag, ":visits"}, 32'(runs_sel.size()), 32'(exp_sel.size()));
        if (runs_sel.size() == exp_sel.size()) begin
            for (int i = 0; i < exp_sel.size(); i++) begin
                checkOutput($sformatf("%s:visit%0d_sel", tag, i), 32'(runs_sel[i]), 32'(exp_sel[i]));
                checkOutput($sformatf("%s:visit%0d_len", tag, i), 32'(runs_len[i]), 32'(cur_s + 1));
            end
        end
        if (mask == 4'b0000) checkOutput({tag, ":sel_held"}, 32'(o_sel()), 32'(sel_before));

        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("%s:hold%0d_drop", tag, h), 32'(o_drop()), 32'd1);
            checkOutput($sformatf("%s:hold%0d_valid", tag, h), 32'(o_valid()), 32'd1);
            checkOutput($sformatf("%s:hold%0d_data", tag, h), 32'(o_data()), 32'(exp_data));
        end

        // Handshake edge, with a colliding start that must be dropped.
        start      = 1'b1;
        snap_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        snap_ready = 1'b0;
        checkOutput({tag, ":post_valid"}, 32'(o_valid()), 32'd0);
        checkOutput({tag, ":post_busy"},  32'(o_busy()),  32'd0);
        checkOutput({tag, ":post_drop"},  32'(o_drop()),  32'd1);
        checkOutput({tag, ":post_data"},  32'(o_data()),  32'(exp_data));
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found2;
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        use0  = 1'b0;
        cur_s = 2;
        runScan(4'b1111, 4'b1010, 0, "full_1010");
        runScan(4'b0101, 4'b1111, 0, "mask_0101");
        runScan(4'b0000, 4'b1111, 0, "mask_0000");
        runScan(4'b1011, 4'b1001, 5, "hold5");

        for (int r = 0; r < 10; r++) begin
            runScan(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                    $sformatf("rand%0d", r));
        end

        // Reset in the middle of channel 2's settle window.
        runScan(4'b0011, 4'b0011, 0, "pre_reset");
        @(negedge clk);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
        found2 = 1'b0;
        for (int n = 0; n < 50 && !found2; n++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (busy2 && sel2 == 2'd2) found2 = 1'b1;
        end
        checkOutput("reach_ch2", 32'(found2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        runScan(4'b0110, 4'b0000, 0, "after_reset_zero");
        runScan(4'b1111, 4'b0101, 1, "after_reset_full");

        // Zero-settle build.
        resetPulse();
        use0  = 1'b1;
        cur_s = 0;
        checkReset("s0_reset");
        runScan(4'b1111, 4'b0110, 0, "s0_full");
        for (int r = 0; r < 4; r++) begin
            runScan(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                    $sformatf("s0_rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
